output_dwell: RTL and testbench
===============================

Name: output_dwell

Overview:
Output-side conditioner for regulator enable lines. It is the drive-side counterpart of the input debouncer.
- Each bit of DATA_IN is an enable request from sequencer logic.
- Each bit of DATA_OUT is the pin-level enable.
- Enforces minimum on-time and minimum off-time per bit, and staggers turn-on edges across bits to limit inrush.
- FORCE_OFF provides an immediate fault shutdown that overrides all dwell timing.

Parameters:
P_WIDTH, 8, number of enable bits.
P_MIN_ON_CLKS, 16, minimum cycles DATA_OUT[i] stays high after rising; must be >= 1.
P_MIN_OFF_CLKS, 16, minimum cycles DATA_OUT[i] stays low after falling; must be >= 1.
P_STAGGER_CLKS, 8, minimum cycles between any two rising edges on DATA_OUT; 0 = no stagger.

Ports:
CLOCK  in  1  single clock; all logic on posedge.
RESET_N  in  1  asynchronous, active-low reset.
DATA_IN  in  P_WIDTH  enable requests; synchronous to CLOCK, no synchronizers inside.
FORCE_OFF  in  1  level; while high, all outputs are driven low.
DATA_OUT  out  P_WIDTH  registered enables.
BUSY  out  P_WIDTH  combinational DATA_IN ^ DATA_OUT: request pending.

Behaviour:
- Reset (async assert, sync release):
  - DATA_OUT = 0.
  - Every bit enters OFF_READY (off dwell treated as already satisfied).
  - Stagger timer is expired.
  - First turn-on after reset is delayed only by stagger.
- Per-bit FSM states:
  - OFF_DWELL: out 0, counting down.
  - OFF_READY: out 0.
  - ON_DWELL: out 1, counting down.
  - ON_READY: out 1.
- Latency: from a ready state, a DATA_IN change appears on DATA_OUT at the next edge (1 cycle).
- Turn-on: a bit in OFF_READY with DATA_IN[i]=1 rises at the next edge only if it holds the stagger grant.
  - Grant goes to the lowest-index eligible bit, one grant per stagger interval.
  - With P_STAGGER_CLKS=0, all eligible bits rise on the same edge.
- Stagger timing: if any bit rises at edge k, no bit may rise before edge k+P_STAGGER_CLKS.
  - Timer reloads on every grant.
  - Timer counts down regardless of requests.
- Turn-off: a bit in ON_READY with DATA_IN[i]=0 falls at the next edge.
  - No stagger on turn-off; any number of bits may fall on the same edge.
- Minimum on-time: if DATA_OUT[i] rises at edge k, the earliest fall is edge k+P_MIN_ON_CLKS.
  - If DATA_IN[i] is already low by then, the fall happens exactly at that edge.
- Minimum off-time: if DATA_OUT[i] falls at edge k, the earliest rise is edge k+P_MIN_OFF_CLKS (subject also to stagger).
- Requests during a dwell:
  - DATA_IN is not latched during dwell.
  - The decision uses the DATA_IN level at dwell expiry and afterwards.
  - A request pulse entirely inside a dwell window has no effect.
- FORCE_OFF=1:
  - All DATA_OUT bits go 0 at the next edge, overriding ON_DWELL.
  - Every bit that was high enters OFF_DWELL with a fresh P_MIN_OFF_CLKS count.
  - Bits already in OFF_DWELL keep their count; bits in OFF_READY stay in OFF_READY.
  - No grants are issued while FORCE_OFF is high.
  - The stagger timer keeps counting.
- Simultaneous events:
  - FORCE_OFF beats any turn-on.
  - A bit's own turn-off and another bit's turn-on on the same edge are independent.
- Counter width: $clog2(max(P_MIN_ON_CLKS,P_MIN_OFF_CLKS)+1) per bit; $clog2(P_STAGGER_CLKS+1) for the stagger timer (min 1 bit).
- Counters saturate at zero and never wrap.

Decomposition:
- Shared package holds:
  - the dwell state enum (OFF_DWELL, OFF_READY, ON_DWELL, ON_READY);
  - a width helper function for the counters.
- Sub-module output_dwell_bit: one per bit via generate.
  - Contains the FSM and dwell counter.
  - Inputs: req, grant, force_off.
  - Outputs: out, eligible.
- Top level holds:
  - the stagger timer;
  - the lowest-index priority grant;
  - BUSY.

Test Plan:
All scenarios use P_WIDTH=4, P_MIN_ON_CLKS=8, P_MIN_OFF_CLKS=6, P_STAGGER_CLKS=4.
1. Reset released, DATA_IN=4'b0001 sampled at edge t -> DATA_OUT=4'b0001 at edge t+1; BUSY[0] high only during cycle t.
2. DATA_IN=4'b1111 sampled at edge t -> bits 0,1,2,3 rise at edges t+1, t+5, t+9, t+13.
3. Bit0 rises at edge k; DATA_IN[0] dropped at k+2 -> fall at k+8; DATA_IN[0] re-raised at k+9 -> rise at k+14.
4. Bit1 in ON_DWELL; DATA_IN[1] low for 3 cycles, then high again, all before dwell expiry -> DATA_OUT[1] never falls.
5. DATA_OUT=4'b0011, with bit0 in ON_DWELL; FORCE_OFF pulsed for one cycle at edge f; DATA_IN held 4'b0011 -> DATA_OUT=0 at f+1; bit0 re-rises at f+7, bit1 at f+11.
6. RESET_N asserted mid-ON_DWELL -> DATA_OUT=0 asynchronously; after release with DATA_IN=4'b0100 -> bit2 rises on the first edge after release, with no off-dwell delay.

Source files
------------

// File: rtl/output_dwell_pkg.sv
// rtl/output_dwell_pkg.sv - shared dwell state encoding and counter sizing helpers
package output_dwell_pkg;

    typedef enum logic [1:0] {
        OFF_DWELL = 2'd0,
        OFF_READY = 2'd1,
        ON_DWELL  = 2'd2,
        ON_READY  = 2'd3
    } dwell_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/output_dwell_bit.sv
// rtl/output_dwell_bit.sv - per-bit on/off dwell FSM with registered enable output
module output_dwell_bit
    import output_dwell_pkg::*;
#(
    parameter int P_MIN_ON_CLKS  = 16,
    parameter int P_MIN_OFF_CLKS = 16,
    parameter int P_CNT_W        = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic grant_i,
    input  logic force_off_i,
    output logic out_o,
    output logic eligible_o
);

    // A dwell of N cycles loads N-1 so the decision lands exactly N edges later.
    localparam logic [P_CNT_W-1:0] ON_LOAD  = P_CNT_W'(P_MIN_ON_CLKS - 1);
    localparam logic [P_CNT_W-1:0] OFF_LOAD = P_CNT_W'(P_MIN_OFF_CLKS - 1);

    dwell_state_e       state_q;
    logic [P_CNT_W-1:0] cnt_q;
    logic               out_q;
    logic               dwell_done;

    assign dwell_done = (cnt_q == '0);
    assign eligible_o = !force_off_i && req_i &&
                        ((state_q == OFF_READY) || ((state_q == OFF_DWELL) && dwell_done));
    assign out_o      = out_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= OFF_READY;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else if (force_off_i) begin
            out_q <= 1'b0;
            case (state_q)
                ON_DWELL, ON_READY: begin
                    state_q <= OFF_DWELL;
                    cnt_q   <= OFF_LOAD;
                end
                OFF_DWELL: if (!dwell_done) cnt_q <= cnt_q - P_CNT_W'(1);
                default: ;
            endcase
        end else begin
            case (state_q)
                OFF_DWELL, OFF_READY: begin
                    if ((state_q == OFF_DWELL) && !dwell_done) begin
                        cnt_q <= cnt_q - P_CNT_W'(1);
                    end else if (eligible_o && grant_i) begin
                        state_q <= ON_DWELL;
                        cnt_q   <= ON_LOAD;
                        out_q   <= 1'b1;
                    end else begin
                        state_q <= OFF_READY;
                    end
                end
                ON_DWELL, ON_READY: begin
                    if ((state_q == ON_DWELL) && !dwell_done) begin
                        cnt_q <= cnt_q - P_CNT_W'(1);
                    end else if (!req_i) begin
                        state_q <= OFF_DWELL;
                        cnt_q   <= OFF_LOAD;
                        out_q   <= 1'b0;
                    end else begin
                        state_q <= ON_READY;
                    end
                end
                default: state_q <= OFF_READY;
            endcase
        end
    end

endmodule

// File: rtl/output_dwell.sv
// rtl/output_dwell.sv - staggered, dwell-limited regulator enable conditioner
module output_dwell
    import output_dwell_pkg::*;
#(
    parameter int P_WIDTH        = 8,
    parameter int P_MIN_ON_CLKS  = 16,
    parameter int P_MIN_OFF_CLKS = 16,
    parameter int P_STAGGER_CLKS = 8
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic [P_WIDTH-1:0] DATA_IN,
    input  logic               FORCE_OFF,
    output logic [P_WIDTH-1:0] DATA_OUT,
    output logic [P_WIDTH-1:0] BUSY
);

    localparam int CNT_W       = cnt_width(max2(P_MIN_ON_CLKS, P_MIN_OFF_CLKS));
    localparam int STAG_W      = cnt_width(P_STAGGER_CLKS);
    localparam int STAG_LOAD_I = (P_STAGGER_CLKS > 0) ? P_STAGGER_CLKS - 1 : 0;
    localparam logic [STAG_W-1:0] STAG_LOAD = STAG_W'(STAG_LOAD_I);

    logic [P_WIDTH-1:0] eligible;
    logic [P_WIDTH-1:0] grant;
    logic [STAG_W-1:0]  stag_q;
    logic [STAG_W-1:0]  stag_d;

    // Lowest-index eligible bit wins; x & -x isolates the lowest set bit.
    always_comb begin
        grant = '0;
        if (!FORCE_OFF) begin
            if (P_STAGGER_CLKS == 0) begin
                grant = eligible;
            end else if (stag_q == '0) begin
                grant = eligible & (~eligible + P_WIDTH'(1));
            end
        end
    end

    always_comb begin
        stag_d = (stag_q != '0) ? stag_q - STAG_W'(1) : '0;
        if (|grant) stag_d = STAG_LOAD;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) stag_q <= '0;
        else          stag_q <= stag_d;
    end

    for (genvar i = 0; i < P_WIDTH; i++) begin : g_bit
        output_dwell_bit #(
            .P_MIN_ON_CLKS (P_MIN_ON_CLKS),
            .P_MIN_OFF_CLKS(P_MIN_OFF_CLKS),
            .P_CNT_W       (CNT_W)
        ) u_bit (
            .clk_i      (CLOCK),
            .rst_ni     (RESET_N),
            .req_i      (DATA_IN[i]),
            .grant_i    (grant[i]),
            .force_off_i(FORCE_OFF),
            .out_o      (DATA_OUT[i]),
            .eligible_o (eligible[i])
        );
    end

    assign BUSY = DATA_IN ^ DATA_OUT;

endmodule

// File: tb/tb_output_dwell.sv
// tb/tb_output_dwell.sv - randomized and directed bench against a timestamp reference model
module tb_output_dwell;

    localparam int W   = 4;
    localparam int ON  = 8;
    localparam int OFF = 6;
    localparam int S   = 4;

    logic         CLOCK = 1'b0;
    logic         RESET_N;
    logic [W-1:0] DATA_IN;
    logic         FORCE_OFF;
    logic [W-1:0] DATA_OUT;
    logic [W-1:0] BUSY;

    always #5 CLOCK = ~CLOCK;

    output_dwell #(
        .P_WIDTH       (W),
        .P_MIN_ON_CLKS (ON),
        .P_MIN_OFF_CLKS(OFF),
        .P_STAGGER_CLKS(S)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .DATA_IN  (DATA_IN),
        .FORCE_OFF(FORCE_OFF),
        .DATA_OUT (DATA_OUT),
        .BUSY     (BUSY)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: edge index n plus timestamps of each bit's last rise/fall.
    int           n = 0;
    logic [W-1:0] m_out;
    int           rise_t[W];
    int           fall_t[W];
    int           last_rise;

    // Edges at which the DUT was actually seen to change.
    logic [W-1:0] prev_out;
    int           dut_rise[W];
    int           dut_fall[W];
    int           fall_cnt[W];

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, n);
        end
    endtask

    task automatic model_reset();
        m_out     = '0;
        last_rise = -1000;
        for (int i = 0; i < W; i++) begin
            rise_t[i] = -1000;
            fall_t[i] = -1000;
        end
    endtask

    task automatic model_edge(input logic [W-1:0] din, input logic frc);
        logic [W-1:0] nxt;
        bit           granted;
        n++;
        nxt = m_out;
        if (frc) begin
            for (int i = 0; i < W; i++) if (m_out[i]) fall_t[i] = n;
            nxt = '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (m_out[i] && !din[i] && n >= rise_t[i] + ON) begin
                    nxt[i]    = 1'b0;
                    fall_t[i] = n;
                end
            end
            granted = 1'b0;
            if (n >= last_rise + S) begin
                for (int i = 0; i < W; i++) begin
                    if (!granted && !m_out[i] && din[i] && n >= fall_t[i] + OFF) begin
                        nxt[i]    = 1'b1;
                        rise_t[i] = n;
                        last_rise = n;
                        granted   = 1'b1;
                    end
                end
            end
        end
        m_out = nxt;
    endtask

    task automatic track();
        for (int i = 0; i < W; i++) begin
            if (DATA_OUT[i] && !prev_out[i]) dut_rise[i] = n;
            if (!DATA_OUT[i] && prev_out[i]) begin
                dut_fall[i] = n;
                fall_cnt[i]++;
            end
        end
        prev_out = DATA_OUT;
    endtask

    // Entered and left at posedge+1.
    task automatic step(input logic [W-1:0] din, input logic frc);
        DATA_IN   = din;
        FORCE_OFF = frc;
        #1 check("busy", int'(BUSY), int'(din ^ m_out));
        @(posedge CLOCK);
        model_edge(din, frc);
        #1 check("data_out", int'(DATA_OUT), int'(m_out));
        track();
    endtask

    task automatic apply_reset(input logic [W-1:0] din);
        #1 RESET_N = 1'b0;
        #1 check("reset_async", int'(DATA_OUT), 0);
        model_reset();
        prev_out  = '0;
        DATA_IN   = din;
        FORCE_OFF = 1'b0;
        @(negedge CLOCK);
        RESET_N = 1'b1;
        @(posedge CLOCK);
        model_edge(din, 1'b0);
        #1 check("post_reset_out", int'(DATA_OUT), int'(m_out));
        track();
    endtask

    initial begin
        int           t;
        int           k;
        int           f;
        int           r;
        int           falls;
        logic [W-1:0] din;
        logic         frc;

        RESET_N   = 1'b0;
        DATA_IN   = '0;
        FORCE_OFF = 1'b0;
        prev_out  = '0;
        model_reset();
        for (int i = 0; i < W; i++) begin
            dut_rise[i] = -1;
            dut_fall[i] = -1;
            fall_cnt[i] = 0;
        end
        #3;
        check("reset_out", int'(DATA_OUT), 0);
        check("reset_busy", int'(BUSY), 0);
        @(posedge CLOCK);

        // Scenario 1: one-cycle latency from reset, BUSY only while pending.
        apply_reset('0);
        DATA_IN = 4'b0001;
        #1 check("s1_busy_pending", int'(BUSY), 1);
        step(4'b0001, 1'b0);
        check("s1_out", int'(DATA_OUT), 1);
        step(4'b0001, 1'b0);
        check("s1_busy_clear", int'(BUSY), 0);

        // Scenario 2: staggered turn-on of all bits.
        apply_reset('0);
        t = n;
        repeat (14) step(4'b1111, 1'b0);
        check("s2_rise0", dut_rise[0] - t, 1);
        check("s2_rise1", dut_rise[1] - t, 5);
        check("s2_rise2", dut_rise[2] - t, 9);
        check("s2_rise3", dut_rise[3] - t, 13);

        // Scenario 3: minimum on-time then minimum off-time.
        apply_reset('0);
        k = n + 1;
        repeat (2) step(4'b0001, 1'b0);
        repeat (7) step(4'b0000, 1'b0);
        repeat (6) step(4'b0001, 1'b0);
        check("s3_fall", dut_fall[0] - k, 8);
        check("s3_rerise", dut_rise[0] - k, 14);

        // Scenario 4: request glitch inside on-dwell is ignored.
        repeat (4) step(4'b0011, 1'b0);
        r     = dut_rise[1];
        falls = fall_cnt[1];
        check("s4_bit1_up", int'(DATA_OUT[1]), 1);
        repeat (3) step(4'b0001, 1'b0);
        repeat (10) step(4'b0011, 1'b0);
        check("s4_no_fall", fall_cnt[1] - falls, 0);
        check("s4_rise_same", dut_rise[1], r);

        // Scenario 5: one-cycle force-off during bit0 on-dwell.
        apply_reset('0);
        repeat (4) step(4'b0010, 1'b0);
        repeat (2) step(4'b0011, 1'b0);
        check("s5_pre", int'(DATA_OUT), 3);
        f = n;
        step(4'b0011, 1'b1);
        check("s5_forced", int'(DATA_OUT), 0);
        repeat (12) step(4'b0011, 1'b0);
        check("s5_rise0", dut_rise[0] - f, 7);
        check("s5_rise1", dut_rise[1] - f, 11);

        // Scenario 6: async reset mid on-dwell, no off-dwell after release.
        step(4'b0011, 1'b0);
        apply_reset(4'b0100);
        check("s6_rise2", int'(DATA_OUT), 4);

        // Random traffic with occasional force-off pulses and resets.
        din = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) din = din ^ W'(1 << $urandom_range(0, W - 1));
            frc = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 799) == 0) apply_reset(din);
            else                             step(din, frc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
